// File: rtl/wptr_full_if.sv
// wptr_full_if
//   Write-side pointer/flag bundle between the FIFO write controller and its
//   producer / memory / read-domain synchronizer.
//   Producer-side inputs : winc, wq2_rptr (synchronized Gray read pointer), wovf_clr
//   Controller outputs   : waddr, wptr (Gray), wfull, walmost_full, wcount, woverflow
//   master = producer side, slave = wptr_full block.
interface wptr_full_if #(
  parameter int ADDRSIZE = 8
);
  logic                winc;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic                wovf_clr;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wcount;
  logic                woverflow;

  modport master (
    output winc, wq2_rptr, wovf_clr,
    input  waddr, wptr, wfull, walmost_full, wcount, woverflow
  );

  modport slave (
    input  winc, wq2_rptr, wovf_clr,
    output waddr, wptr, wfull, walmost_full, wcount, woverflow
  );
endinterface

// File: rtl/wptr_full.sv
// wptr_full
//   Write-domain pointer and status controller for an asynchronous FIFO.
//   Owns the binary write pointer, publishes the Gray write pointer for the
//   read-domain synchronizer, and derives full / almost-full / occupancy from
//   the already-synchronized Gray read pointer. Also keeps a sticky overflow
//   flag for writes attempted while full (such writes are dropped).
//   Ports:
//     wclk    write clock, rising edge
//     wrst_n  async active-low reset
//     wif     wptr_full_if.slave: winc, wq2_rptr, wovf_clr in;
//             waddr, wptr, wfull, walmost_full, wcount, woverflow out
module wptr_full #(
  parameter int ADDRSIZE     = 8,
  parameter int AFULL_THRESH = 4
) (
  input  logic        wclk,
  input  logic        wrst_n,
  wptr_full_if.slave  wif
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] DEPTH    = {1'b1, {ADDRSIZE{1'b0}}};
  localparam logic [PW-1:0] AF_LEVEL = DEPTH - PW'(AFULL_THRESH);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wptr_q;
  logic          wfull_q;
  logic          walmost_full_q;
  logic [PW-1:0] wcount_q;
  logic          woverflow_q;

  logic          wen;
  logic [PW-1:0] wbinnext;
  logic [PW-1:0] wgraynext;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] wcount_next;
  logic [PW-1:0] rptr_full_pattern;
  logic          wfull_next;
  logic          walmost_full_next;
  logic          woverflow_next;

  assign wen       = wif.winc & ~wfull_q;
  assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wen};
  assign wgraynext = (wbinnext >> 1) ^ wbinnext;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i < PW; i++) begin
      rbin_s[i] = ^(wif.wq2_rptr >> i);
    end
  end

  // Modular subtraction keeps occupancy correct across pointer wrap.
  assign wcount_next = wbinnext - rbin_s;

  // Full in Gray space: write pointer is one lap ahead, which flips the top
  // two Gray bits relative to the read pointer.
  assign rptr_full_pattern = {~wif.wq2_rptr[PW-1:PW-2], wif.wq2_rptr[PW-3:0]};
  assign wfull_next        = (wgraynext == rptr_full_pattern);
  assign walmost_full_next = (wcount_next >= AF_LEVEL);

  // Set takes priority over clear so a concurrent overflow is never lost.
  assign woverflow_next = (woverflow_q & ~wif.wovf_clr) | (wif.winc & wfull_q);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin           <= '0;
      wptr_q         <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wcount_q       <= '0;
      woverflow_q    <= 1'b0;
    end else begin
      wbin           <= wbinnext;
      wptr_q         <= wgraynext;
      wfull_q        <= wfull_next;
      walmost_full_q <= walmost_full_next;
      wcount_q       <= wcount_next;
      woverflow_q    <= woverflow_next;
    end
  end

  assign wif.waddr        = wbin[ADDRSIZE-1:0];
  assign wif.wptr         = wptr_q;
  assign wif.wfull        = wfull_q;
  assign wif.walmost_full = walmost_full_q;
  assign wif.wcount       = wcount_q;
  assign wif.woverflow    = woverflow_q;

endmodule
